// File: rtl/bldc_mul_sched_pkg.sv
// Shared types and constants for the BLDC multiplier scheduler.
// Duty scaling is floor(a*b/100), saturated at 255.
package bldc_mul_sched_pkg;

  localparam int OPW        = 8;
  localparam int PW         = 2 * OPW;
  localparam int DUTY_SCALE = 100;
  localparam int DUTY_MAX   = 255;
  localparam int DUTY_SAT   = DUTY_SCALE * (DUTY_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RESP  = 2'd2
  } state_t;

endpackage

// File: rtl/bldc_rr_pick.sv
// Round-robin picker: first valid requester at or above the pointer,
// wrapping modulo N; returns one-hot grant and binary index.
module bldc_rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  valid_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  logic [IW:0] slot;
  logic        found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    slot    = '0;
    for (int k = 0; k < N; k++) begin
      slot = {1'b0, ptr_i} + (IW+1)'(k);
      if (slot >= (IW+1)'(N)) begin
        slot = slot - (IW+1)'(N);
      end
      if (!found && valid_i[slot[IW-1:0]]) begin
        found                   = 1'b1;
        grant_o[slot[IW-1:0]]   = 1'b1;
        idx_o                   = slot[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/bldc_mul_sched.sv
// Round-robin sharing of one 8x8 multiplier, result scaled to PWM duty.
// Optional ISSUE timeout: define BLDC_MUL_SCHED_TIMEOUT_EN.
module bldc_mul_sched
  import bldc_mul_sched_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [OPW-1:0]      rsp_data,
  output logic                rsp_err,
  output logic                mul_load,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic                mul_valid,
  input  logic [PW-1:0]       mul_prod
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("bldc_mul_sched: unsupported NREQ/TIMEOUT");
  end

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            mul_load_q, mul_load_d;
  logic [OPW-1:0]  mul_a_q, mul_a_d;
  logic [OPW-1:0]  mul_b_q, mul_b_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [OPW-1:0]  rsp_data_q, rsp_data_d;
  logic [NREQ-1:0] pick_grant;
  logic [IW-1:0]   pick_idx;
  logic [OPW-1:0]  duty;
  logic            expire;

  bldc_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx)
  );

  // Anything at or above 25600 would exceed 255 after scaling.
  assign duty = (mul_prod >= PW'(DUTY_SAT)) ? OPW'(DUTY_MAX)
                : OPW'(mul_prod / PW'(DUTY_SCALE));

`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          rsp_err_q, rsp_err_d;
  assign expire  = (cnt_q == CW'(TIMEOUT - 1));
  assign rsp_err = rsp_err_q;
`else
  assign expire  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ptr_d       = ptr_q;
    mul_load_d  = mul_load_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (|pick_grant) begin
          state_d    = S_ISSUE;
          idx_d      = pick_idx;
          mul_load_d = 1'b1;
          for (int i = 0; i < NREQ; i++) begin
            if (pick_grant[i]) begin
              mul_a_d = req_a[OPW*i +: OPW];
              mul_b_d = req_b[OPW*i +: OPW];
            end
          end
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
          cnt_d = '0;
`endif
        end
      end
      S_ISSUE: begin
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
        cnt_d = cnt_q + CW'(1);
`endif
        // A product on the expiry cycle still counts as a normal result.
        if (mul_valid || expire) begin
          state_d     = S_RESP;
          mul_load_d  = 1'b0;
          rsp_valid_d = NREQ'(1) << idx_q;
          rsp_data_d  = mul_valid ? duty : '0;
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
          rsp_err_d   = !mul_valid;
`endif
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        ptr_d   = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ptr_q       <= '0;
      mul_load_q  <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ptr_q       <= ptr_d;
      mul_load_q  <= mul_load_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef BLDC_MUL_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_d;
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  // Grant is held off while reset is asserted so nothing is offered.
  assign req_ready = (state_q == S_IDLE && rst_n) ? pick_grant : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign mul_load  = mul_load_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;

endmodule
